store_merge_unit: RTL and testbench
===================================

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 Parameter: READ_LAT, 1, memory read latency in cycles from mem_rd to valid mem_rdata; legal range 1..4.
REQ-002 Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  1  store request; sampled only while busy=0.
REQ-005 size  input  2  store width: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-006 addr  input  32  byte address of store.
REQ-007 wdata  input  32  register value; low 8/16/32 bits are stored per size.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 done  output  1  one-cycle pulse at completion of an accepted request.
REQ-010 err  output  1  high only in the done cycle of a rejected request.
REQ-011 mem_addr  output  32  word address {addr_q[31:2],2'b00}; 0 in IDLE.
REQ-012 mem_rd  output  1  one-cycle word-read strobe.
REQ-013 mem_rdata  input  32  read data; valid in the READ_LAT-th cycle after the mem_rd cycle.
REQ-014 mem_wr  output  1  one-cycle word-write strobe.
REQ-015 mem_wdata  output  32  merged write word; valid while mem_wr=1, else 0.

Function
REQ-016 Block SHALL narrow a 32-bit register value into a word-only memory without byte enables, using read-modify-write for byte/halfword stores.
REQ-017 States SHALL be IDLE, READ, WAIT, WRITE, DONE.
REQ-018 In IDLE with req=1, the block SHALL latch addr, size and wdata (addr_q, size_q, wdata_q) and leave IDLE at that edge; later input changes SHALL have no effect.
REQ-019 req while busy=1 SHALL be ignored, neither queued nor flagged.
REQ-020 Byte/halfword: IDLE -> READ (mem_rd=1, one cycle) -> WAIT (READ_LAT cycles, down-counter) -> WRITE (mem_wr=1) -> DONE (done=1) -> IDLE.
REQ-021 mem_rdata SHALL be captured at the edge ending the last WAIT cycle.
REQ-022 Word: IDLE -> WRITE (mem_wdata=wdata_q, no read) -> DONE -> IDLE.
REQ-023 Lanes are little-endian: byte offset k=addr_q[1:0] SHALL replace bits [8k+7:8k] with wdata_q[7:0]; halfword offset 0/2 SHALL replace [15:0]/[31:16] with wdata_q[15:0]; all other bits SHALL equal captured read data.
REQ-024 Latency from accept edge: byte/half done in cycle 3+READ_LAT; word done in cycle 2.
REQ-025 Exactly one mem_wr pulse SHALL occur per accepted non-rejected request; none for rejected requests.
REQ-026 done and err SHALL be registered outputs; the state returns to IDLE the cycle after DONE, so back-to-back requests have a 1-cycle gap minimum.

Reset
REQ-027 Reset=1 SHALL immediately force state IDLE, counter 0, latched registers 0, and all outputs 0.
REQ-028 Reset during READ/WAIT/WRITE SHALL abort the operation; no mem_wr or done SHALL follow after release.
REQ-029 First req SHALL be accepted on the first rising edge with Reset=0.

Configuration
REQ-030 With STORE_ALIGN_CHECK_EN defined: size=11, halfword with addr[0]=1, or word with addr[1:0]!=0 SHALL go IDLE -> DONE with done=1, err=1, and no memory access.
REQ-031 Without STORE_ALIGN_CHECK_EN: err SHALL be tied 0; size=11 SHALL be treated as word; halfword ignores addr[0]; word ignores addr[1:0].

Verification
REQ-032 READ_LAT=1, sb addr=0x00000013 wdata=0x123456AB, mem_rdata=0xDEADBEEF -> mem_rd cycle 1, mem_wr cycle 3 with mem_addr=0x00000010 mem_wdata=0xABADBEEF, done cycle 4.
REQ-033 READ_LAT=1, sh addr=0x00000022 wdata=0xFFFFC0DE, mem_rdata=0x11112222 -> mem_wr mem_addr=0x00000020 mem_wdata=0xC0DE2222, err=0.
REQ-034 sw addr=0x00000040 wdata=0xCAFEF00D -> no mem_rd, mem_wr cycle 1 with mem_wdata=0xCAFEF00D, done cycle 2.
REQ-035 With STORE_ALIGN_CHECK_EN, sh addr=0x00000021 -> done=1 err=1 cycle 1, no mem_rd/mem_wr; without macro -> merge into [15:0] at 0x00000020.
REQ-036 READ_LAT=3, sb accepted, Reset pulsed in second WAIT cycle -> all outputs 0 immediately, no mem_wr; new sw afterwards completes in 2 cycles.
REQ-037 req held high with varying addr during a byte store -> only first request executed; exactly one mem_wr per accepted request.

Source files
------------

// File: rtl/store_merge_unit.sv
// Narrows 32-bit register stores onto a word-only memory, using read-modify-write for byte/halfword.
// Optional macro STORE_ALIGN_CHECK_EN rejects reserved sizes and misaligned halfword/word stores.
module store_merge_unit #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr,
  output logic [31:0] mem_wdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [1:0] LAT_M1  = 2'(READ_LAT - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        reject;

  // Little-endian lane insert; sizes 10 and 11 both write the whole register value.
  function automatic logic [31:0] merge_word(input logic [31:0] rd, input logic [31:0] wd,
                                             input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] m;
    m = rd;
    case (sz)
      2'b00:   m[{off, 3'b000} +: 8] = wd[7:0];
      2'b01:   if (off[1]) m[31:16] = wd[15:0]; else m[15:0] = wd[15:0];
      default: m = wd;
    endcase
    return m;
  endfunction

`ifdef STORE_ALIGN_CHECK_EN
  always_comb begin
    reject = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
             (size == 2'b10 && addr[1:0] != 2'b00);
  end
`else
  always_comb begin
    reject = 1'b0;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          size_d  = size;
          addr_d  = addr;
          wdata_d = wdata;
          if (reject) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (size[1]) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        state_d = S_WAIT;
        cnt_d   = LAT_M1;
      end
      S_WAIT: begin
        // Read data is valid exactly in the last WAIT cycle.
        if (cnt_q == 2'd0) begin
          rdata_d = mem_rdata;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mem_rd    = (state_q == S_READ);
  assign mem_wr    = (state_q == S_WRITE);
  assign mem_addr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata = mem_wr ? merge_word(rdata_q, wdata_q, size_q, addr_q[1:0]) : 32'd0;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: one instance with READ_LAT=1 and one with READ_LAT=3.
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req1, req3;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rd_val;

  logic        busy1, done1, err1, rd1, wr1;
  logic [31:0] maddr1, mwd1, mrd1;
  logic        busy3, done3, err3, rd3, wr3;
  logic [31:0] maddr3, mwd3, mrd3;

  logic        rd1_d = 1'b0;
  logic [2:0]  rd3_sh = 3'b000;

  int n_cmp = 0;
  int n_bad = 0;
  int sel;

  always #5 clk = ~clk;

  store_merge_unit #(.READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy1), .done(done1), .err(err1), .mem_addr(maddr1), .mem_rd(rd1),
    .mem_rdata(mrd1), .mem_wr(wr1), .mem_wdata(mwd1));

  store_merge_unit #(.READ_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req3), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy3), .done(done3), .err(err3), .mem_addr(maddr3), .mem_rd(rd3),
    .mem_rdata(mrd3), .mem_wr(wr3), .mem_wdata(mwd3));

  // Memory model: data only valid in the READ_LAT-th cycle after the read strobe.
  always @(posedge clk) begin
    rd1_d  <= rd1;
    rd3_sh <= {rd3_sh[1:0], rd3};
  end
  assign mrd1 = rd1_d     ? rd_val : 32'h5A5A5A5A;
  assign mrd3 = rd3_sh[2] ? rd_val : 32'h5A5A5A5A;

  logic        o_busy, o_done, o_err, o_rd, o_wr;
  logic [31:0] o_addr, o_wd;
  always_comb begin
    if (sel == 1) begin
      o_busy = busy3; o_done = done3; o_err = err3; o_rd = rd3; o_wr = wr3;
      o_addr = maddr3; o_wd = mwd3;
    end else begin
      o_busy = busy1; o_done = done1; o_err = err1; o_rd = rd1; o_wr = wr1;
      o_addr = maddr1; o_wd = mwd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int          r_nrd, r_nwr, r_rd_cyc, r_wr_cyc, r_done_cyc, r_err, r_bad;
  logic [31:0] r_wdata, r_waddr;

  // Issue one request at a falling edge and trace the DUT for a bounded number of cycles.
  task automatic run(input int s, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rv, input bit hold);
    sel = s; rd_val = rv; size = sz; addr = a; wdata = wd;
    req1 = (s == 0); req3 = (s == 1);
    r_nrd = 0; r_nwr = 0; r_rd_cyc = 0; r_wr_cyc = 0; r_done_cyc = 0; r_err = 0; r_bad = 0;
    r_wdata = 32'd0; r_waddr = 32'd0;
    @(posedge clk);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (o_rd) begin r_nrd++; r_rd_cyc = c; end
      if (o_wr) begin r_nwr++; r_wr_cyc = c; r_wdata = o_wd; r_waddr = o_addr; end
      if (!o_wr && o_wd != 32'd0) r_bad++;
      if (!o_busy && o_addr != 32'd0) r_bad++;
      if (o_err && !o_done) r_bad++;
      if (o_done) begin r_done_cyc = c; r_err = o_err ? 1 : 0; end
      if (!hold || r_done_cyc != 0) begin req1 = 1'b0; req3 = 1'b0; end
      addr = $urandom; wdata = $urandom; size = 2'($urandom);
      if (r_done_cyc != 0 && c >= r_done_cyc + 2) break;
    end
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] a, wd, rv;
    bit          rmw, mis;
    logic [31:0] ew, ea;
  } vec_t;

  vec_t v[9];

  initial begin
    int rej, nw, nd, nb;
    v[0] = '{2'b00, 32'h00000013, 32'h123456AB, 32'hDEADBEEF, 1'b1, 1'b0, 32'hABADBEEF, 32'h00000010};
    v[1] = '{2'b01, 32'h00000022, 32'hFFFFC0DE, 32'h11112222, 1'b1, 1'b0, 32'hC0DE2222, 32'h00000020};
    v[2] = '{2'b10, 32'h00000040, 32'hCAFEF00D, 32'h00000000, 1'b0, 1'b0, 32'hCAFEF00D, 32'h00000040};
    v[3] = '{2'b01, 32'h00000021, 32'h0000BEEF, 32'h11112222, 1'b1, 1'b1, 32'h1111BEEF, 32'h00000020};
    v[4] = '{2'b00, 32'h00000000, 32'h000000FF, 32'h12345678, 1'b1, 1'b0, 32'h123456FF, 32'h00000000};
    v[5] = '{2'b00, 32'h00000105, 32'h00000077, 32'hAABBCCDD, 1'b1, 1'b0, 32'hAABB77DD, 32'h00000104};
    v[6] = '{2'b00, 32'h00000106, 32'h0000005A, 32'hAABBCCDD, 1'b1, 1'b0, 32'hAA5ACCDD, 32'h00000104};
    v[7] = '{2'b11, 32'h00000083, 32'h01020304, 32'h00000000, 1'b0, 1'b1, 32'h01020304, 32'h00000080};
    v[8] = '{2'b10, 32'h00000047, 32'h89ABCDEF, 32'h00000000, 1'b0, 1'b1, 32'h89ABCDEF, 32'h00000044};

    rst = 1'b1; sel = 0; req1 = 1'b1; req3 = 1'b1;
    size = 2'b10; addr = 32'h00000044; wdata = 32'h11223344; rd_val = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl1", {27'd0, busy1, done1, err1, rd1, wr1}, 32'd0);
    chk("rst_bus1", maddr1 | mwd1, 32'd0);
    chk("rst_ctrl3", {27'd0, busy3, done3, err3, rd3, wr3}, 32'd0);
    chk("rst_bus3", maddr3 | mwd3, 32'd0);
    req1 = 1'b0; req3 = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
`ifdef STORE_ALIGN_CHECK_EN
      rej = v[i].mis ? 1 : 0;
`else
      rej = 0;
`endif
      run(0, v[i].sz, v[i].a, v[i].wd, v[i].rv, 1'b0);
      if (rej != 0) begin
        chk($sformatf("v%0d_nrd", i), r_nrd, 0);
        chk($sformatf("v%0d_nwr", i), r_nwr, 0);
        chk($sformatf("v%0d_done", i), r_done_cyc, 1);
        chk($sformatf("v%0d_err", i), r_err, 1);
      end else begin
        chk($sformatf("v%0d_nrd", i), r_nrd, v[i].rmw ? 1 : 0);
        chk($sformatf("v%0d_rdcyc", i), r_rd_cyc, v[i].rmw ? 1 : 0);
        chk($sformatf("v%0d_nwr", i), r_nwr, 1);
        chk($sformatf("v%0d_wrcyc", i), r_wr_cyc, v[i].rmw ? 3 : 1);
        chk($sformatf("v%0d_wdata", i), r_wdata, v[i].ew);
        chk($sformatf("v%0d_waddr", i), r_waddr, v[i].ea);
        chk($sformatf("v%0d_done", i), r_done_cyc, v[i].rmw ? 4 : 2);
        chk($sformatf("v%0d_err", i), r_err, 0);
      end
      chk($sformatf("v%0d_idlebus", i), r_bad, 0);
    end

    // req held high while addr/wdata change: only the first request runs.
    run(0, 2'b00, 32'h00000013, 32'h123456AB, 32'hDEADBEEF, 1'b1);
    chk("hold_nwr", r_nwr, 1);
    chk("hold_nrd", r_nrd, 1);
    chk("hold_wdata", r_wdata, 32'hABADBEEF);
    chk("hold_waddr", r_waddr, 32'h00000010);
    chk("hold_done", r_done_cyc, 4);

    // READ_LAT=3 byte store aborted by reset in its second WAIT cycle.
    sel = 1; rd_val = 32'h01020304; size = 2'b00; addr = 32'h00000201; wdata = 32'h000000EE;
    req3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req3 = 1'b0;
    chk("abort_rd", {31'd0, rd3}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_pre", {31'd0, busy3}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_ctrl", {27'd0, busy3, done3, err3, rd3, wr3}, 32'd0);
    chk("abort_bus", maddr3 | mwd3, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nw = 0; nd = 0; nb = 0;
    repeat (8) begin
      @(negedge clk);
      if (wr3) nw++;
      if (done3) nd++;
      if (busy3) nb++;
    end
    chk("abort_nwr", nw, 0);
    chk("abort_ndone", nd, 0);
    chk("abort_nbusy", nb, 0);

    run(1, 2'b10, 32'h00000300, 32'h13572468, 32'h0, 1'b0);
    chk("post_nwr", r_nwr, 1);
    chk("post_wrcyc", r_wr_cyc, 1);
    chk("post_wdata", r_wdata, 32'h13572468);
    chk("post_waddr", r_waddr, 32'h00000300);
    chk("post_done", r_done_cyc, 2);

    // READ_LAT=3 halfword: capture must use the data of the last WAIT cycle.
    run(1, 2'b01, 32'h00000402, 32'h0000BEEF, 32'h76543210, 1'b0);
    chk("lat3_rdcyc", r_rd_cyc, 1);
    chk("lat3_wrcyc", r_wr_cyc, 5);
    chk("lat3_wdata", r_wdata, 32'hBEEF3210);
    chk("lat3_done", r_done_cyc, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
